// File: rtl/adc_cap_pkg.sv
// Shared types and widths for the ADC trigger/capture block.
package adc_cap_pkg;

  localparam int SAMPLE_W = 8;
  localparam int PERIOD_W = 21;

  typedef enum logic [2:0] {
    IDLE,
    PRETRIG,
    ARMED,
    POST,
    DONE
  } cap_state_e;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample buffer: one write port, one read port with a registered
// output. A read and a write to the same address in one cycle return the old data.
module capture_ram #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // NOTE: the array itself has no reset so it maps onto block RAM; only the
  // output register is reset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/adc_trigger_capture.sv
// Oscilloscope-style capture: rolling pre-trigger buffer, rising-edge trigger with
// auto timeout, post-trigger fill, frozen frame. Define TRIG_HYST_EN for a hysteresis trigger.
module adc_trigger_capture
  import adc_cap_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int PRE     = 256,
  parameter int AUTO_TO = 2**20 - 1,
  parameter int HYST    = 8,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                Rst,
  input  logic [SAMPLE_W-1:0] ADC_Data,
  input  logic                ADC_Valid,
  input  logic [SAMPLE_W-1:0] Trigger_Gate,
  input  logic                Rearm,
  input  logic [AW-1:0]       Read_Addr,
  output logic [SAMPLE_W-1:0] ADC_Data_Out,
  output logic [PERIOD_W-1:0] Period,
  output logic                Capture_Done,
  output logic                ADC_En
);

  localparam int POST_LEN = DEPTH - PRE;

  if (PRE < 1 || PRE >= DEPTH || (DEPTH & (DEPTH - 1)) != 0 || HYST < 0) begin : g_bad_cfg
    $error("adc_trigger_capture: illegal DEPTH/PRE/HYST combination");
  end

  cap_state_e          state_q, state_d;
  logic [AW-1:0]       wr_addr_q, wr_addr_d;
  logic [AW-1:0]       start_addr_q, start_addr_d;
  logic [PERIOD_W-1:0] phase_cnt_q, phase_cnt_d;
  logic [PERIOD_W-1:0] smp_cnt_q, smp_cnt_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                done_q;
  logic                we;
  logic                sample_en;
  logic                crossing;

  assign sample_en = ADC_Valid && (state_q != IDLE);

`ifdef TRIG_HYST_EN
  // A crossing needs a prior dip below the gate minus the hysteresis band.
  logic                arm_q;
  logic [SAMPLE_W-1:0] thr_lo;

  assign thr_lo   = (int'(Trigger_Gate) > HYST) ? Trigger_Gate - SAMPLE_W'(HYST) : '0;
  assign crossing = sample_en && arm_q && (ADC_Data >= Trigger_Gate);

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      arm_q <= 1'b0;
    end else if (sample_en) begin
      if (crossing)                arm_q <= 1'b0;
      else if (ADC_Data < thr_lo)  arm_q <= 1'b1;
    end
  end
`else
  logic [SAMPLE_W-1:0] prev_q;

  assign crossing = sample_en && (prev_q < Trigger_Gate) && (ADC_Data >= Trigger_Gate);

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst)           prev_q <= '1;
    else if (sample_en) prev_q <= ADC_Data;
  end
`endif

  // phase_cnt counts valid samples within the current PRETRIG/ARMED/POST phase.
  always_comb begin
    // NOTE: every signal assigned here gets its default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d      = state_q;
    wr_addr_d    = wr_addr_q;
    start_addr_d = start_addr_q;
    phase_cnt_d  = phase_cnt_q;
    we           = 1'b0;

    unique case (state_q)
      IDLE: begin
        state_d     = PRETRIG;
        phase_cnt_d = '0;
      end
      PRETRIG: if (ADC_Valid) begin
        we          = 1'b1;
        phase_cnt_d = phase_cnt_q + 1'b1;
        if (phase_cnt_q + 1'b1 == PERIOD_W'(PRE)) begin
          state_d     = ARMED;
          phase_cnt_d = '0;
        end
      end
      ARMED: if (ADC_Valid) begin
        we          = 1'b1;
        phase_cnt_d = phase_cnt_q + 1'b1;
        if (crossing || (phase_cnt_q + 1'b1 == PERIOD_W'(AUTO_TO))) begin
          // The trigger sample lands at wr_addr_q and is the first post sample.
          start_addr_d = wr_addr_q - AW'(PRE);
          phase_cnt_d  = PERIOD_W'(1);
          state_d      = (POST_LEN == 1) ? DONE : POST;
        end
      end
      POST: if (ADC_Valid) begin
        we          = 1'b1;
        phase_cnt_d = phase_cnt_q + 1'b1;
        if (phase_cnt_q + 1'b1 == PERIOD_W'(POST_LEN)) state_d = DONE;
      end
      DONE: if (Rearm) begin
        state_d     = PRETRIG;
        phase_cnt_d = '0;
      end
      default: state_d = IDLE;
    endcase

    if (we) wr_addr_d = wr_addr_q + 1'b1;
  end

  // Free-running sample counter between crossings; a forced trigger is not a crossing.
  always_comb begin
    smp_cnt_d = smp_cnt_q;
    period_d  = period_q;
    if (sample_en) begin
      if (crossing) begin
        period_d  = smp_cnt_q;
        smp_cnt_d = PERIOD_W'(1);
      end else if (smp_cnt_q != '1) begin
        smp_cnt_d = smp_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state_q      <= IDLE;
      wr_addr_q    <= '0;
      start_addr_q <= '0;
      phase_cnt_q  <= '0;
      smp_cnt_q    <= '0;
      period_q     <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_addr_q    <= wr_addr_d;
      start_addr_q <= start_addr_d;
      phase_cnt_q  <= phase_cnt_d;
      smp_cnt_q    <= smp_cnt_d;
      period_q     <= period_d;
      done_q       <= (state_d == DONE);
    end
  end

  capture_ram #(
    .DEPTH (DEPTH),
    .WIDTH (SAMPLE_W),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .rst_n   (Rst),
    .we_i    (we),
    .waddr_i (wr_addr_q),
    .wdata_i (ADC_Data),
    .raddr_i (start_addr_q + Read_Addr),
    .rdata_o (ADC_Data_Out)
  );

  assign Period       = period_q;
  assign Capture_Done = done_q;
  assign ADC_En       = (state_q != IDLE);

endmodule
